// File: rtl/adc_spi_master_pkg.sv
// Shared command encodings, FSM state type and sample-format helpers for the
// stereo ADC SPI master.
package adc_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [1:0] CMD_L = 2'b10;
    localparam logic [1:0] CMD_R = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        XFER_L,
        XFER_R,
        WAIT
    } state_t;

    function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [1:0] sel);
        return {sel, {(FRAME_BITS-2){1'b0}}};
    endfunction

    // Offset binary to 1.15 two's complement: flipping the MSB recentres zero.
    function automatic logic [FRAME_BITS-1:0] to_twos(input logic [FRAME_BITS-1:0] offset_word);
        return {~offset_word[FRAME_BITS-1], offset_word[FRAME_BITS-2:0]};
    endfunction

endpackage

// File: rtl/adc_spi_master_if.sv
// ADC-side SPI pins; the master drives clock, command and chip select.
interface adc_spi_master_if;

    logic adc_sck;
    logic adc_sdi;
    logic adc_sdo;
    logic adc_cs_n;

    modport master (output adc_sck, output adc_sdi, output adc_cs_n, input adc_sdo);
    modport slave  (input adc_sck, input adc_sdi, input adc_cs_n, output adc_sdo);

endinterface

// File: rtl/adc_spi_master_shifter.sv
// Single 16-bit SPI frame engine: SCK divider, bit counter and both shift
// registers. o_done is combinational so the next frame can start seamlessly.
module adc_spi_shifter
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = FRAME_BITS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_word,
    input  logic              i_sdo,
    output logic              o_sck,
    output logic              o_sdi,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_word
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic              r_active;
    logic              r_sck;
    logic              r_sdi;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              w_phase_end;
    logic              w_last_bit;

    assign w_phase_end = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));
    assign o_done      = r_active && r_sck && w_phase_end && w_last_bit;
    assign o_sck       = r_sck;
    assign o_sdi       = r_sdi;
    assign o_rx_word   = r_rx;

    // A start on the done cycle overrides the final falling edge, so frames
    // can run back to back with no extra low time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_sdi    <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_sdi    <= i_tx_word[DATA_W-1];
            r_tx     <= {i_tx_word[DATA_W-2:0], 1'b0};
            r_cnt    <= '0;
            r_bit    <= '0;
        end else if (r_active) begin
            if (w_phase_end) begin
                r_cnt <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[DATA_W-2:0], i_sdo};
                end else begin
                    r_sck <= 1'b0;
                    r_sdi <= r_tx[DATA_W-1];
                    r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
                    r_bit <= r_bit + BIT_W'(1);
                    if (w_last_bit) begin
                        r_active <= 1'b0;
                    end
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_spi_master.sv
// Stereo ADC SPI master: primes the ADC command pipeline, then fetches one
// L/R pair per FRAME_PERIOD and presents it in 1.15 two's complement.
module adc_spi_master
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int FRAME_PERIOD = 1000,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    adc_spi_master_if.master  spi,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    output logic              busy
);

    localparam int PCNT_W = $clog2(FRAME_PERIOD);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("adc_spi_master: CLK_DIV must be at least 2");
    end
    if (FRAME_PERIOD < 64 * CLK_DIV + 2) begin : g_bad_frame_period
        $error("adc_spi_master: FRAME_PERIOD must be at least 64*CLK_DIV+2");
    end

    state_t            r_state;
    state_t            w_next;
    logic [PCNT_W-1:0] r_pcnt;
    logic              r_cs_n;
    logic              r_valid;
    logic [DATA_W-1:0] r_pend_l;
    logic [DATA_W-1:0] r_sample_l;
    logic [DATA_W-1:0] r_sample_r;
    logic              w_start;
    logic [DATA_W-1:0] w_tx_word;
    logic              w_done;
    logic [DATA_W-1:0] w_rx_word;
    logic              w_load_l;
    logic              w_load_pair;
    logic              w_enter_l;
    logic              w_sck;
    logic              w_sdi;

    adc_spi_shifter #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_start),
        .i_tx_word (w_tx_word),
        .i_sdo     (spi.adc_sdo),
        .o_sck     (w_sck),
        .o_sdi     (w_sdi),
        .o_done    (w_done),
        .o_rx_word (w_rx_word)
    );

    assign spi.adc_sck  = w_sck;
    assign spi.adc_sdi  = w_sdi;
    assign spi.adc_cs_n = r_cs_n;
    assign busy         = ~r_cs_n;
    assign sample_l     = r_sample_l;
    assign sample_r     = r_sample_r;
    assign sample_valid = r_valid;
    assign w_enter_l    = (w_next == XFER_L) && (r_state != XFER_L);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Each command is answered one frame later, so every frame sends the
    // command for the next channel while receiving the current one.
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_tx_word   = cmd_word(CMD_L);
        w_load_l    = 1'b0;
        w_load_pair = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next  = PRIME;
                    w_start = 1'b1;
                end
            end
            PRIME: begin
                if (w_done) begin
                    w_next    = XFER_L;
                    w_start   = 1'b1;
                    w_tx_word = cmd_word(CMD_R);
                end
            end
            XFER_L: begin
                if (w_done) begin
                    w_next   = XFER_R;
                    w_start  = 1'b1;
                    w_load_l = 1'b1;
                end
            end
            XFER_R: begin
                if (w_done) begin
                    w_next      = WAIT;
                    w_load_pair = 1'b1;
                end
            end
            WAIT: begin
                if (!en) begin
                    w_next = IDLE;
                end else if (r_pcnt == PCNT_W'(FRAME_PERIOD - 1)) begin
                    w_next    = XFER_L;
                    w_start   = 1'b1;
                    w_tx_word = cmd_word(CMD_R);
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt     <= '0;
            r_cs_n     <= 1'b1;
            r_valid    <= 1'b0;
            r_pend_l   <= '0;
            r_sample_l <= '0;
            r_sample_r <= '0;
        end else begin
            r_cs_n  <= (w_next == IDLE);
            r_valid <= w_load_pair;
            if (w_enter_l || r_state == IDLE || r_state == PRIME) begin
                r_pcnt <= '0;
            end else if (r_pcnt == PCNT_W'(FRAME_PERIOD - 1)) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PCNT_W'(1);
            end
            if (w_load_l) begin
                r_pend_l <= to_twos(w_rx_word);
            end
            if (w_load_pair) begin
                r_sample_l <= r_pend_l;
                r_sample_r <= to_twos(w_rx_word);
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: an ADC model answering each command one frame
// later, plus a per-cycle checker of bus timing, commands and sample pairs.
module tb_adc_spi_master;

    localparam int CD = 4;
    localparam int FP = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        busy;

    adc_spi_master_if spi();

    adc_spi_master #(
        .CLK_DIV      (CD),
        .FRAME_PERIOD (FP),
        .DATA_W       (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .spi          (spi),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mode = 1;

    int          rises = 0;
    int          frame_idx = 0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_sdi = 1'b0;
    logic [15:0] rx_cmd = '0;
    logic [15:0] resp = '0;
    logic [15:0] prev_cmd = '0;
    logic [15:0] pend_l = '0;
    logic [15:0] exp_l = '0;
    logic [15:0] exp_r = '0;
    logic [15:0] hold_l = '0;
    logic [15:0] hold_r = '0;
    bit          armed = 1'b0;
    int          cd = 0;
    int          last_valid = -1;
    int          last_rise = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ADC answer for a command: mode 1 and 2 are fixed patterns, 0 is random.
    function automatic logic [15:0] pick(input logic [15:0] cmd);
        logic [15:0] v;
        v = 16'hDEAD;
        if (cmd == 16'h8000) begin
            case (mode)
                1:       v = 16'h8005;
                2:       v = 16'hFFFF;
                default: v = 16'($urandom_range(0, 65535));
            endcase
        end else if (cmd == 16'hC000) begin
            case (mode)
                1:       v = 16'h4000;
                2:       v = 16'h0000;
                default: v = 16'($urandom_range(0, 65535));
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin
        logic        exp_v;
        logic [15:0] exp_cmd;
        cyc++;
        if (!reset_n) begin
            chk("rst_sck", spi.adc_sck, 1'b0);
            chk("rst_sdi", spi.adc_sdi, 1'b0);
            chk("rst_cs_n", spi.adc_cs_n, 1'b1);
            chk("rst_sample_l", sample_l, 16'h0000);
            chk("rst_sample_r", sample_r, 16'h0000);
            chk("rst_valid", sample_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            armed = 1'b0;
            hold_l = '0;
            hold_r = '0;
            prev_cs = 1'b1;
            prev_sck = 1'b0;
            prev_sdi = 1'b0;
            rises = 0;
            frame_idx = 0;
            last_valid = -1;
            last_rise = -1;
            spi.adc_sdo = 1'b0;
        end else begin
            if (armed && cd > 0) cd--;
            exp_v = armed && (cd == 0);
            chk("valid", sample_valid, exp_v);
            if (exp_v) begin
                armed = 1'b0;
                hold_l = exp_l;
                hold_r = exp_r;
            end
            if (sample_valid) begin
                chk("sample_l", sample_l, exp_l);
                chk("sample_r", sample_r, exp_r);
                if (last_valid >= 0) chk("pair_spacing", cyc - last_valid, FP);
                last_valid = cyc;
            end else begin
                chk("hold_l", sample_l, hold_l);
                chk("hold_r", sample_r, hold_r);
            end
            chk("busy", busy, !spi.adc_cs_n);
            if (spi.adc_cs_n) begin
                chk("idle_sck", spi.adc_sck, 1'b0);
                last_valid = -1;
            end
            if (prev_cs && !spi.adc_cs_n) begin
                rises = 0;
                frame_idx = 0;
                resp = 16'h1234;
                last_rise = -1;
            end
            if (spi.adc_sdi !== prev_sdi)
                chk("sdi_change_point", !spi.adc_sck && (prev_sck || rises == 0 || rises == 16), 1'b1);
            if (spi.adc_sck && !prev_sck) begin
                if (rises == 16) rises = 0;
                if (rises > 0) chk("sck_period", cyc - last_rise, 2 * CD);
                last_rise = cyc;
                rx_cmd = {rx_cmd[14:0], spi.adc_sdi};
                rises++;
                if (rises == 16) begin
                    exp_cmd = (frame_idx % 2 == 1) ? 16'hC000 : 16'h8000;
                    chk("cmd", rx_cmd, exp_cmd);
                    if (frame_idx > 0) begin
                        if (prev_cmd == 16'h8000) begin
                            pend_l = resp;
                        end else if (prev_cmd == 16'hC000) begin
                            exp_l = pend_l - 16'h8000;
                            exp_r = resp - 16'h8000;
                            armed = 1'b1;
                            cd = CD;
                        end
                    end
                    prev_cmd = rx_cmd;
                    resp = pick(rx_cmd);
                    frame_idx++;
                end
            end
            if (!spi.adc_sck && prev_sck) chk("sck_high", cyc - last_rise, CD);
            spi.adc_sdo = resp[15 - (rises % 16)];
            prev_sck = spi.adc_sck;
            prev_cs = spi.adc_cs_n;
            prev_sdi = spi.adc_sdi;
        end
    end

    task automatic wait_valid(input string nm, input int budget);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clk);
            if (sample_valid) hit = 1'b1;
        end
        chk({nm, "_seen"}, hit, 1'b1);
    endtask

    task automatic wait_pos(input string nm, input bit want_even, input int bitn, input int budget);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clk);
            if (frame_idx > 0 && ((frame_idx % 2 == 0) == want_even) && rises == bitn) hit = 1'b1;
        end
        chk({nm, "_reached"}, hit, 1'b1);
    endtask

    initial begin
        mode = 1;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #2 en = 1'b1;

        wait_valid("first_pair", 3000);
        chk("lit_first_l", sample_l, 16'h0005);
        chk("lit_first_r", sample_r, 16'hC000);

        mode = 0;
        repeat (12) wait_valid("run_pair", 1500);

        wait_pos("stop_in_xfer_l", 1'b0, 8, 3000);
        en = 1'b0;
        wait_valid("last_pair", 1500);
        @(negedge clk);
        chk("cs_after_stop", spi.adc_cs_n, 1'b1);
        repeat (200) @(negedge clk);
        chk("stopped_sck", spi.adc_sck, 1'b0);
        chk("stopped_busy", busy, 1'b0);

        mode = 2;
        #2 en = 1'b1;
        wait_valid("full_scale_pair", 3000);
        chk("lit_full_l", sample_l, 16'h7FFF);
        chk("lit_full_r", sample_r, 16'h8000);

        mode = 0;
        repeat (2) wait_valid("pre_reset_pair", 1500);
        wait_pos("reset_in_xfer_r", 1'b1, 7, 3000);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_sck", spi.adc_sck, 1'b0);
        chk("async_rst_sdi", spi.adc_sdi, 1'b0);
        chk("async_rst_cs_n", spi.adc_cs_n, 1'b1);
        chk("async_rst_sample_l", sample_l, 16'h0000);
        chk("async_rst_sample_r", sample_r, 16'h0000);
        chk("async_rst_valid", sample_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) wait_valid("post_reset_pair", 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
